// File: rtl/ahbl_trace_pkg.sv
// ahbl_trace_pkg
// Shared definitions for the AHB-Lite trace monitor:
//   - HTRANS / HRESP encodings as seen on the snooped bus
//   - bit offsets used to pack one trace record into a FIFO word
//     (err, write, size, addr, then data and optional timestamp,
//     whose offsets depend on the top-level AW/DW parameters)
//   - pending-transfer FSM state type and small decode helpers
package ahbl_trace_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Fixed low part of a packed record; address follows, then data.
  localparam int REC_ERR_OFS   = 0;
  localparam int REC_WRITE_OFS = 1;
  localparam int REC_SIZE_OFS  = 2;
  localparam int REC_SIZE_W    = 3;
  localparam int REC_ADDR_OFS  = REC_SIZE_OFS + REC_SIZE_W;

  typedef enum logic {
    PEND_IDLE   = 1'b0,
    PEND_DPHASE = 1'b1
  } pend_state_e;

  // Only NONSEQ and SEQ carry a real transfer.
  function automatic logic htrans_is_transfer(input logic [1:0] htrans);
    logic r;
    case (htrans)
      HTRANS_NONSEQ, HTRANS_SEQ: r = 1'b1;
      HTRANS_IDLE, HTRANS_BUSY:  r = 1'b0;
      default:                   r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic hresp_is_error(input logic hresp);
    logic r;
    case (hresp)
      HRESP_ERROR: r = 1'b1;
      HRESP_OKAY:  r = 1'b0;
      default:     r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// trace_fifo
// Generic synchronous first-word-fall-through FIFO.
// Ports:
//   clk, rstn        clock, asynchronous active-low reset
//   clr_i            synchronous flush, wins over push and pop
//   push_i, din_i    write request and data; a push while full is
//                    accepted only if a pop happens in the same cycle
//   pop_i            read request, ignored while empty
//   dout_o           head entry, forced to zero while empty
//   full_o, empty_o  status flags
//   level_o          occupancy, reaches DEPTH exactly when full
module trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     clr_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         din_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW:0]      r_wr_ptr;
  logic [PW:0]      r_rd_ptr;
  logic             w_push_ok;
  logic             w_pop_ok;

  // Pointers carry one extra wrap bit so full and empty differ.
  assign empty_o   = (r_wr_ptr == r_rd_ptr);
  assign full_o    = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                     (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
  assign level_o   = r_wr_ptr - r_rd_ptr;
  assign w_pop_ok  = pop_i & ~empty_o;
  assign w_push_ok = push_i & (~full_o | w_pop_ok);
  assign dout_o    = empty_o ? '0 : r_mem[r_rd_ptr[PW-1:0]];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (clr_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: nothing is visible until a push lands.
  always_ff @(posedge clk) begin
    if (w_push_ok && !clr_i) r_mem[r_wr_ptr[PW-1:0]] <= din_i;
  end

endmodule

// File: rtl/ahbl_trace_monitor.sv
// ahbl_trace_monitor
// Passive AHB-Lite transaction tracer. Each accepted address phase is
// held in a pending register until its data phase completes
// (hready_i=1), at which point one record is pushed into a FWFT FIFO
// drained through a valid/ready stream. Records that find the FIFO
// full are dropped and counted.
// Ports:
//   clk, rstn                    bus clock, async active-low reset
//   en_i                         gates new address phases only
//   clr_i                        flush FIFO, drop counter, overflow and
//                                any pending transfer
//   win_base_i / win_mask_i      address window (mask bit 1 = compare)
//   htrans_i..hresp_i            snooped AHB-Lite master signals
//   rec_valid_o / rec_ready_i    record stream handshake
//   rec_addr_o..rec_err_o        record fields
//   rec_ts_o                     completion timestamp
//   level_o                      FIFO occupancy
//   drop_cnt_o / overflow_o      saturating drop count, sticky flag
// Build option: define TRACE_TIMESTAMP_EN to add a free-running
// timestamp stored with each record; otherwise rec_ts_o is zero.
module ahbl_trace_monitor #(
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int DEPTH = 16,
  parameter int CNT_W = 16,
  parameter int TS_W  = 32
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     en_i,
  input  logic                     clr_i,
  input  logic [AW-1:0]            win_base_i,
  input  logic [AW-1:0]            win_mask_i,
  input  logic [1:0]               htrans_i,
  input  logic [AW-1:0]            haddr_i,
  input  logic                     hwrite_i,
  input  logic [2:0]               hsize_i,
  input  logic [DW-1:0]            hwdata_i,
  input  logic [DW-1:0]            hrdata_i,
  input  logic                     hready_i,
  input  logic                     hresp_i,
  output logic                     rec_valid_o,
  input  logic                     rec_ready_i,
  output logic [AW-1:0]            rec_addr_o,
  output logic [DW-1:0]            rec_data_o,
  output logic                     rec_write_o,
  output logic [2:0]               rec_size_o,
  output logic                     rec_err_o,
  output logic [TS_W-1:0]          rec_ts_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic [CNT_W-1:0]         drop_cnt_o,
  output logic                     overflow_o
);

  import ahbl_trace_pkg::*;

  localparam int DATA_OFS = REC_ADDR_OFS + AW;
`ifdef TRACE_TIMESTAMP_EN
  localparam int TS_OFS   = DATA_OFS + DW;
  localparam int REC_W    = TS_OFS + TS_W;
`else
  localparam int REC_W    = DATA_OFS + DW;
`endif

  pend_state_e      r_state;
  pend_state_e      w_next_state;
  logic [AW-1:0]    r_pend_addr;
  logic             r_pend_write;
  logic [2:0]       r_pend_size;
  logic             w_win_hit;
  logic             w_accept;
  logic             w_push;
  logic             w_pop;
  logic             w_drop;
  logic             w_full;
  logic             w_empty;
  logic [REC_W-1:0] w_rec_in;
  logic [REC_W-1:0] w_rec_out;
  logic [CNT_W-1:0] r_drop_cnt;
  logic             r_overflow;

  assign w_win_hit = (((haddr_i ^ win_base_i) & win_mask_i) == '0);
  assign w_accept  = hready_i & htrans_is_transfer(htrans_i) & en_i & w_win_hit;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= PEND_IDLE;
    else       r_state <= w_next_state;
  end

  // A completing data phase may overlap the next accepted address
  // phase, in which case the FSM stays in DPHASE for the new transfer.
  always_comb begin
    w_next_state = r_state;
    w_push       = 1'b0;
    case (r_state)
      PEND_IDLE: begin
        if (w_accept) w_next_state = PEND_DPHASE;
      end
      PEND_DPHASE: begin
        if (hready_i) begin
          w_push       = 1'b1;
          w_next_state = w_accept ? PEND_DPHASE : PEND_IDLE;
        end
      end
      default: w_next_state = PEND_IDLE;
    endcase
    if (clr_i) begin
      w_next_state = PEND_IDLE;
      w_push       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pend_addr  <= '0;
      r_pend_write <= 1'b0;
      r_pend_size  <= '0;
    end else if (w_accept && !clr_i) begin
      r_pend_addr  <= haddr_i;
      r_pend_write <= hwrite_i;
      r_pend_size  <= hsize_i;
    end
  end

`ifdef TRACE_TIMESTAMP_EN
  logic [TS_W-1:0] r_ts;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_ts <= '0;
    else       r_ts <= r_ts + 1'b1;
  end
`endif

  always_comb begin
    w_rec_in                              = '0;
    w_rec_in[REC_ERR_OFS]                 = hresp_is_error(hresp_i);
    w_rec_in[REC_WRITE_OFS]               = r_pend_write;
    w_rec_in[REC_SIZE_OFS +: REC_SIZE_W]  = r_pend_size;
    w_rec_in[REC_ADDR_OFS +: AW]          = r_pend_addr;
    w_rec_in[DATA_OFS +: DW]              = r_pend_write ? hwdata_i : hrdata_i;
`ifdef TRACE_TIMESTAMP_EN
    w_rec_in[TS_OFS +: TS_W]              = r_ts;
`endif
  end

  // A pop in the same cycle frees the slot a full FIFO needs.
  assign w_pop  = ~w_empty & rec_ready_i;
  assign w_drop = w_push & w_full & ~w_pop;

  trace_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .clr_i   (clr_i),
    .push_i  (w_push),
    .din_i   (w_rec_in),
    .pop_i   (w_pop),
    .dout_o  (w_rec_out),
    .full_o  (w_full),
    .empty_o (w_empty),
    .level_o (level_o)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_drop_cnt <= '0;
      r_overflow <= 1'b0;
    end else if (clr_i) begin
      r_drop_cnt <= '0;
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + 1'b1;
      r_overflow <= 1'b1;
    end
  end

  assign rec_valid_o = ~w_empty;
  assign rec_err_o   = w_rec_out[REC_ERR_OFS];
  assign rec_write_o = w_rec_out[REC_WRITE_OFS];
  assign rec_size_o  = w_rec_out[REC_SIZE_OFS +: REC_SIZE_W];
  assign rec_addr_o  = w_rec_out[REC_ADDR_OFS +: AW];
  assign rec_data_o  = w_rec_out[DATA_OFS +: DW];
`ifdef TRACE_TIMESTAMP_EN
  assign rec_ts_o    = w_rec_out[TS_OFS +: TS_W];
`else
  assign rec_ts_o    = '0;
`endif
  assign drop_cnt_o  = r_drop_cnt;
  assign overflow_o  = r_overflow;

endmodule

// File: tb/tb_ahbl_trace_monitor.sv
// tb_ahbl_trace_monitor
// Drives the snooped bus as an AHB-Lite master (scripted and random
// transfers with wait states and error responses) and predicts the
// record stream, FIFO occupancy and drop statistics from the
// transactions it issued.
module tb_ahbl_trace_monitor;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        en_i = 1'b1;
  logic        clr_i = 1'b0;
  logic [31:0] win_base_i = '0;
  logic [31:0] win_mask_i = '0;
  logic [1:0]  htrans_i = '0;
  logic [31:0] haddr_i = '0;
  logic        hwrite_i = 1'b0;
  logic [2:0]  hsize_i = '0;
  logic [31:0] hwdata_i = '0;
  logic [31:0] hrdata_i = '0;
  logic        hready_i = 1'b1;
  logic        hresp_i = 1'b0;
  logic        rec_valid_o;
  logic        rec_ready_i = 1'b0;
  logic [31:0] rec_addr_o;
  logic [31:0] rec_data_o;
  logic        rec_write_o;
  logic [2:0]  rec_size_o;
  logic        rec_err_o;
  logic [31:0] rec_ts_o;
  logic [4:0]  level_o;
  logic [15:0] drop_cnt_o;
  logic        overflow_o;

  always #5 clk = ~clk;

  ahbl_trace_monitor #(
    .AW(32), .DW(32), .DEPTH(DEPTH), .CNT_W(16), .TS_W(32)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .en_i        (en_i),
    .clr_i       (clr_i),
    .win_base_i  (win_base_i),
    .win_mask_i  (win_mask_i),
    .htrans_i    (htrans_i),
    .haddr_i     (haddr_i),
    .hwrite_i    (hwrite_i),
    .hsize_i     (hsize_i),
    .hwdata_i    (hwdata_i),
    .hrdata_i    (hrdata_i),
    .hready_i    (hready_i),
    .hresp_i     (hresp_i),
    .rec_valid_o (rec_valid_o),
    .rec_ready_i (rec_ready_i),
    .rec_addr_o  (rec_addr_o),
    .rec_data_o  (rec_data_o),
    .rec_write_o (rec_write_o),
    .rec_size_o  (rec_size_o),
    .rec_err_o   (rec_err_o),
    .rec_ts_o    (rec_ts_o),
    .level_o     (level_o),
    .drop_cnt_o  (drop_cnt_o),
    .overflow_o  (overflow_o)
  );

  typedef struct {
    logic [1:0]  trans;
    logic [31:0] addr;
    logic        write;
    logic [2:0]  size;
    logic [31:0] data;
    int          waits;
    bit          err;
  } xfer_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        write;
    logic [2:0]  size;
    logic        err;
    logic [31:0] ts;
  } rec_t;

  int          checks = 0;
  int          errors = 0;
  rec_t        expQ[$];
  xfer_t       script[$];
  int          dropModel = 0;
  bit          ovfModel = 0;
  logic [31:0] tsModel = '0;

  // Master-side view: the transfer currently in its data phase and
  // the address phase currently on the bus.
  bit          dpValid = 0;
  bit          dpCaptured = 0;
  xfer_t       dp;
  int          dpWaitsLeft = 0;
  xfer_t       ap;
  bit          addrFresh = 1;

  int          readyPct = 100;
  int          idlePct = 100;
  int          errPct = 0;
  int          maxWaits = 0;

  // Every comparison funnels through here.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h at %0t",
               tag, observed, expected, $time);
    end
  endtask

  function automatic xfer_t mkXfer(input logic [31:0] addr, input logic write,
                                   input logic [31:0] data, input int waits,
                                   input bit err);
    xfer_t x;
    x.trans = 2'b10;
    x.addr  = addr;
    x.write = write;
    x.size  = 3'd2;
    x.data  = data;
    x.waits = waits;
    x.err   = err;
    return x;
  endfunction

  function automatic xfer_t idleXfer();
    xfer_t x;
    x = mkXfer(32'h0, 1'b0, 32'h0, 0, 1'b0);
    x.trans = 2'b00;
    return x;
  endfunction

  function automatic xfer_t randXfer();
    xfer_t x;
    int    r;
    r = $urandom_range(99);
    x.addr  = $urandom;
    x.write = 1'($urandom_range(1));
    x.size  = 3'($urandom_range(2));
    x.data  = $urandom;
    x.waits = $urandom_range(maxWaits);
    x.err   = ($urandom_range(99) < errPct);
    if (x.err && x.waits == 0) x.waits = 1;
    if (r < idlePct)          x.trans = 2'b00;
    else if (r < idlePct + 5) x.trans = 2'b01;
    else                      x.trans = $urandom_range(1) ? 2'b10 : 2'b11;
    case ($urandom_range(3))
      0:       x.addr = 32'h4000_0010;
      1:       x.addr = 32'h0000_0010;
      2:       x.addr = 32'h0000_0100 + 32'($urandom_range(63) * 4);
      default: x.addr = $urandom;
    endcase
    return x;
  endfunction

  task automatic checkCycle();
    checkOutput("valid", rec_valid_o, expQ.size() > 0);
    checkOutput("level", level_o, expQ.size());
    checkOutput("dropCnt", drop_cnt_o, dropModel);
    checkOutput("overflow", overflow_o, ovfModel);
    if (expQ.size() > 0) begin
      checkOutput("recAddr", rec_addr_o, expQ[0].addr);
      checkOutput("recData", rec_data_o, expQ[0].data);
      checkOutput("recWrite", rec_write_o, expQ[0].write);
      checkOutput("recSize", rec_size_o, expQ[0].size);
      checkOutput("recErr", rec_err_o, expQ[0].err);
`ifdef TRACE_TIMESTAMP_EN
      checkOutput("recTs", rec_ts_o, expQ[0].ts);
`endif
    end
`ifndef TRACE_TIMESTAMP_EN
    checkOutput("recTsZero", rec_ts_o, 0);
`endif
  endtask

  // One bus cycle: called #1 after a rising edge, returns #1 after the next.
  task automatic applyStimulus();
    bit pop;
    bit complete;
    bit accept;
    if (dpValid && dpWaitsLeft > 0) begin
      hready_i = 1'b0;
      hresp_i  = dp.err && (dpWaitsLeft == 1);
    end else begin
      hready_i = 1'b1;
      hresp_i  = dpValid && dp.err;
    end
    hwdata_i = (dpValid && dp.write)  ? dp.data : $urandom;
    hrdata_i = (dpValid && !dp.write) ? dp.data : $urandom;
    if (addrFresh) begin
      if (dpValid && dp.err)     ap = idleXfer();
      else if (script.size() > 0) ap = script.pop_front();
      else                       ap = randXfer();
    end
    htrans_i    = ap.trans;
    haddr_i     = ap.addr;
    hwrite_i    = ap.write;
    hsize_i     = ap.size;
    rec_ready_i = ($urandom_range(99) < readyPct);

    @(negedge clk);
    checkCycle();
    pop      = (expQ.size() > 0) && rec_ready_i;
    complete = dpValid && hready_i;
    accept   = hready_i && htrans_i[1] && en_i &&
               (((haddr_i ^ win_base_i) & win_mask_i) == 32'h0);

    @(posedge clk);
    if (clr_i) begin
      expQ.delete();
      dropModel = 0;
      ovfModel  = 0;
    end else begin
      if (pop) void'(expQ.pop_front());
      if (complete && dpCaptured) begin
        if (expQ.size() < DEPTH) begin
          expQ.push_back('{addr: dp.addr, data: dp.data, write: dp.write,
                           size: dp.size, err: dp.err, ts: tsModel});
        end else begin
          if (dropModel < 65535) dropModel++;
          ovfModel = 1;
        end
      end
    end
    tsModel = tsModel + 32'd1;
    if (clr_i) dpCaptured = 0;
    if (hready_i) begin
      dpValid     = ap.trans[1];
      dp          = ap;
      dpWaitsLeft = ap.waits;
      dpCaptured  = accept && !clr_i;
      addrFresh   = 1;
    end else begin
      dpWaitsLeft--;
      addrFresh = 0;
    end
    #1;
  endtask

  task automatic resetDut();
    rstn        = 1'b0;
    htrans_i    = 2'b00;
    hready_i    = 1'b1;
    hresp_i     = 1'b0;
    rec_ready_i = 1'b0;
    clr_i       = 1'b0;
    expQ.delete();
    dropModel   = 0;
    ovfModel    = 0;
    tsModel     = '0;
    dpValid     = 0;
    dpCaptured  = 0;
    addrFresh   = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rstValid", rec_valid_o, 0);
    checkOutput("rstLevel", level_o, 0);
    checkOutput("rstDrop", drop_cnt_o, 0);
    checkOutput("rstOverflow", overflow_o, 0);
    checkOutput("rstAddr", rec_addr_o, 0);
    checkOutput("rstData", rec_data_o, 0);
    checkOutput("rstTs", rec_ts_o, 0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  initial begin
    resetDut();

    // Single zero-wait read.
    script.push_back(mkXfer(32'h0000_0100, 1'b0, 32'hDEAD_BEEF, 0, 1'b0));
    repeat (6) applyStimulus();

    // Write with two wait states, read pipelined behind it.
    script.push_back(mkXfer(32'h0000_0200, 1'b1, 32'h1234_5678, 2, 1'b0));
    script.push_back(mkXfer(32'h0000_0204, 1'b0, 32'h0BAD_F00D, 0, 1'b0));
    repeat (8) applyStimulus();

    // Address window: only the 0x4xxx_xxxx access is recorded.
    win_base_i = 32'h4000_0000;
    win_mask_i = 32'hF000_0000;
    script.push_back(mkXfer(32'h4000_0010, 1'b0, 32'h1111_2222, 0, 1'b0));
    script.push_back(mkXfer(32'h0000_0010, 1'b0, 32'h3333_4444, 0, 1'b0));
    repeat (6) applyStimulus();
    win_base_i = '0;
    win_mask_i = '0;

    // Two-cycle ERROR response.
    script.push_back(mkXfer(32'h0000_0300, 1'b0, 32'h5555_6666, 1, 1'b1));
    repeat (6) applyStimulus();

    // Fill past capacity with the consumer stalled, then clear.
    readyPct = 0;
    for (int i = 0; i < 20; i++)
      script.push_back(mkXfer(32'h0000_1000 + 32'(i * 4), 1'b0, $urandom, 0, 1'b0));
    repeat (24) applyStimulus();
    checkOutput("fullLevel", level_o, DEPTH);
    checkOutput("fullDrop", drop_cnt_o, 4);
    checkOutput("fullOverflow", overflow_o, 1);
    clr_i = 1'b1;
    applyStimulus();
    clr_i = 1'b0;
    checkOutput("clrLevel", level_o, 0);
    checkOutput("clrDrop", drop_cnt_o, 0);
    checkOutput("clrOverflow", overflow_o, 0);
    readyPct = 100;

    // Reset in the middle of a wait-stated data phase.
    script.push_back(mkXfer(32'h0000_0500, 1'b0, 32'h7777_8888, 5, 1'b0));
    repeat (3) applyStimulus();
    resetDut();
    script.push_back(mkXfer(32'h0000_0104, 1'b0, 32'hCAFE_F00D, 0, 1'b0));
    repeat (6) applyStimulus();

    // Randomised traffic under varying consumer, wait and filter settings.
    for (int ph = 0; ph < 6; ph++) begin
      case (ph)
        0: begin readyPct = 100; idlePct = 20; maxWaits = 0; errPct = 0;  end
        1: begin readyPct = 50;  idlePct = 30; maxWaits = 3; errPct = 10; end
        2: begin readyPct = 10;  idlePct = 10; maxWaits = 1; errPct = 5;  end
        3: begin readyPct = 80;  idlePct = 40; maxWaits = 3; errPct = 10; end
        4: begin readyPct = 0;   idlePct = 10; maxWaits = 0; errPct = 0;  end
        default: begin readyPct = 70; idlePct = 25; maxWaits = 2; errPct = 5; end
      endcase
      win_base_i = 32'h4000_0000;
      win_mask_i = (ph % 2 == 1) ? 32'hF000_0000 : 32'h0;
      repeat (400) begin
        en_i  = ($urandom_range(99) < 90);
        clr_i = ($urandom_range(199) == 0);
        applyStimulus();
      end
      en_i  = 1'b1;
      clr_i = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
